// File: rtl/ysyx_24100006_if_id_buf.sv
// IF/ID decoupling buffer between the IFU and the IDU. It is a 1-entry pipeline register by default.
// Define YSYX_24100006_IFID_SKID_EN to build a 2-entry skid buffer that has no ready path from the IDU to the IFU.
module ysyx_24100006_if_id_buf #(
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instruction_F,
    input  logic [31:0] pc_F,
    input  logic        flush,
    output logic        id_out_valid,
    input  logic        id_out_ready,
    output logic [31:0] instruction,
    output logic [31:0] pc_D
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // Valid never depends on ready. Once raised, valid and the payload hold until that transfer or a flush.
    logic [1:0]  count;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [31:0] inst_q [2];
    logic [31:0] pc_q   [2];
    logic        has_data;
    logic        push;
    logic        pop;

    assign has_data     = (count != 2'd0);
    assign id_out_valid = has_data & ~flush;

`ifdef YSYX_24100006_IFID_SKID_EN
    // count never exceeds 2, so bit 1 alone means full.
    assign in_ready = ~count[1];
`else
    assign in_ready = ~has_data | id_out_ready;
`endif

    assign push = in_valid & in_ready & ~flush;
    assign pop  = id_out_valid & id_out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef YSYX_24100006_IFID_SKID_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
        end
    end
`else
    // Single slot: both pointers stay on entry 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                inst_q[i] <= 32'h0;
                pc_q[i]   <= 32'h0;
            end
        end else if (push) begin
            inst_q[wr_ptr] <= instruction_F;
            pc_q[wr_ptr]   <= pc_F;
        end
    end

    always_comb begin
        instruction = NOP_INST;
        pc_D        = 32'h0;
        if (has_data) begin
            instruction = inst_q[rd_ptr];
            pc_D        = pc_q[rd_ptr];
        end
    end

endmodule

// File: tb/tb_ysyx_24100006_if_id_buf.sv
// Self-checking bench for ysyx_24100006_if_id_buf. The scoreboard expects the buffer to deliver in FIFO order.
// It follows the YSYX_24100006_IFID_SKID_EN build setting.
module tb_ysyx_24100006_if_id_buf;

    localparam logic [31:0] NOP = 32'h00000013;
`ifdef YSYX_24100006_IFID_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction_F;
    logic [31:0] pc_F;
    logic        flush;
    logic        id_out_valid;
    logic        id_out_ready;
    logic [31:0] instruction;
    logic [31:0] pc_D;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_pop = 0;
    int          m_cnt = 0;
    int          m_nxt = 0;
    logic        exp_rdy;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;

    ysyx_24100006_if_id_buf #(.NOP_INST(NOP)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instruction_F(instruction_F),
        .pc_F         (pc_F),
        .flush        (flush),
        .id_out_valid (id_out_valid),
        .id_out_ready (id_out_ready),
        .instruction  (instruction),
        .pc_D         (pc_D)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard: every accepted output must be the oldest outstanding push
    always @(negedge clk) begin
        if (id_out_valid === 1'b1 && id_out_ready === 1'b1) begin
            n_pop++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pop_unexpected: got pc=%h inst=%h, required no output", pc_D, instruction);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({pc_D, instruction} !== mon_exp) begin
                    n_err++;
                    $display("FAIL pop_order: got pc=%h inst=%h, required pc=%h inst=%h",
                             pc_D, instruction, mon_exp[63:32], mon_exp[31:0]);
                end
            end
        end
    end

    task automatic model_clear();
        exp_q.delete();
        m_cnt = 0;
        m_nxt = 0;
    endtask

    // driver: applies one cycle of inputs and updates the reference model
    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic rdy, input logic fl);
        int p_push;
        int p_pop;
        @(posedge clk);
        #1;
        m_cnt         = m_nxt;
        in_valid      = v;
        pc_F          = pc;
        instruction_F = inst;
        id_out_ready  = rdy;
        flush         = fl;
`ifdef YSYX_24100006_IFID_SKID_EN
        exp_rdy = (m_cnt < 2);
`else
        exp_rdy = (m_cnt == 0) || rdy;
`endif
        if (fl) begin
            exp_q.delete();
            m_nxt = 0;
        end else begin
            p_push = (v && exp_rdy) ? 1 : 0;
            p_pop  = (m_cnt != 0 && rdy) ? 1 : 0;
            if (p_push == 1) exp_q.push_back({pc, inst});
            m_nxt = m_cnt + p_push - p_pop;
        end
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        in_valid      = 1'b1;
        pc_F          = 32'h80000000;
        instruction_F = 32'h00100093;
        id_out_ready  = 1'b1;
        flush         = 1'b0;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (id_out_valid !== 1'b0 || instruction !== NOP || pc_D !== 32'h0) begin
                n_err++;
                $display("FAIL reset_outputs: got v=%b inst=%h pc=%h, required v=0 inst=%h pc=0",
                         id_out_valid, instruction, pc_D, NOP);
            end
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        reset    = 1'b1;
    endtask

    task automatic test_single();
        drive(1'b1, 32'h80000000, 32'h00100093, 1'b1, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (id_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_latency: got v=%b in push cycle, required 0", id_out_valid);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (id_out_valid !== 1'b1 || pc_D !== 32'h80000000 || instruction !== 32'h00100093) begin
            n_err++;
            $display("FAIL single_present: got v=%b pc=%h inst=%h, required v=1 pc=80000000 inst=00100093",
                     id_out_valid, pc_D, instruction);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (id_out_valid !== 1'b0 || instruction !== NOP || pc_D !== 32'h0) begin
            n_err++;
            $display("FAIL single_empty: got v=%b inst=%h pc=%h, required v=0 inst=%h pc=0",
                     id_out_valid, instruction, pc_D, NOP);
        end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 32'h80000000, 32'h00100093, 1'b0, 1'b0);
`ifdef YSYX_24100006_IFID_SKID_EN
        drive(1'b1, 32'h80000004, 32'h00200113, 1'b0, 1'b0);
`endif
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_full: got in_ready=%b, required 0", in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            @(negedge clk);
            n_cmp++;
            if (id_out_valid !== 1'b1 || pc_D !== 32'h80000000 || instruction !== 32'h00100093) begin
                n_err++;
                $display("FAIL bp_hold: got v=%b pc=%h inst=%h, required v=1 pc=80000000 inst=00100093",
                         id_out_valid, pc_D, instruction);
            end
        end
`ifdef YSYX_24100006_IFID_SKID_EN
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
`else
        drive(1'b1, 32'h80000004, 32'h00200113, 1'b1, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_pass_ready: got in_ready=%b, required 1", in_ready);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
`endif
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || pc_D !== 32'h80000004 || id_out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL bp_second: got rdy=%b v=%b pc=%h, required rdy=1 v=1 pc=80000004",
                     in_ready, id_out_valid, pc_D);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL bp_drain: got %0d outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < CAP; i++)
            drive(1'b1, 32'h80000000 + 32'(4 * i), 32'h00000093 + 32'(i), 1'b0, 1'b0);
        drive(1'b1, 32'h80000010, 32'h00500293, 1'b1, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (id_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_mask: got v=%b during flush, required 0", id_out_valid);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (id_out_valid !== 1'b0 || instruction !== NOP || pc_D !== 32'h0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_empty: got v=%b inst=%h pc=%h rdy=%b, required v=0 inst=%h pc=0 rdy=1",
                     id_out_valid, instruction, pc_D, in_ready, NOP);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        drive(1'b1, 32'h80000020, 32'h00600313, 1'b1, 1'b0);
        drive(1'b1, 32'h80000024, 32'h00700393, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL flush_refill: got %0d outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int pop0;
        pop0 = n_pop;
        for (int k = 0; k < 100; k++) begin
            drive(1'b1, 32'h80000000 + 32'(4 * k), $urandom, 1'b1, 1'b0);
            @(negedge clk);
            n_cmp++;
            if (id_out_valid !== (k > 0)) begin
                n_err++;
                $display("FAIL b2b_bubble: k=%0d got v=%b, required %b", k, id_out_valid, (k > 0));
            end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (n_pop - pop0 != 100 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL b2b_count: got %0d pops %0d outstanding, required 100 pops 0 outstanding",
                     n_pop - pop0, exp_q.size());
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'h80000040, 32'h00800413, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (id_out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL areset_held: got v=%b, required 1", id_out_valid);
        end
        @(posedge clk);
        #3;
        reset = 1'b0;
        model_clear();
        #1;
        n_cmp++;
        if (id_out_valid !== 1'b0 || instruction !== NOP || pc_D !== 32'h0) begin
            n_err++;
            $display("FAIL areset_async: got v=%b inst=%h pc=%h, required v=0 inst=%h pc=0",
                     id_out_valid, instruction, pc_D, NOP);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            @(negedge clk);
            n_cmp++;
            if (id_out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL areset_stale: got v=%b pc=%h, required v=0", id_out_valid, pc_D);
            end
        end
        drive(1'b1, 32'h80000044, 32'h00900493, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (id_out_valid !== 1'b1 || pc_D !== 32'h80000044) begin
            n_err++;
            $display("FAIL areset_first: got v=%b pc=%h, required v=1 pc=80000044", id_out_valid, pc_D);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic v;
        logic rdy;
        logic fl;
        for (int i = 0; i < 300; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 19) == 0);
            drive(v, 32'h90000000 + 32'(4 * i), $urandom, rdy, fl);
            @(negedge clk);
            n_cmp++;
            if (in_ready !== exp_rdy || id_out_valid !== (m_cnt != 0 && !fl)) begin
                n_err++;
                $display("FAIL rand_ctrl: cyc %0d got rdy=%b v=%b, required rdy=%b v=%b",
                         i, in_ready, id_out_valid, exp_rdy, (m_cnt != 0 && !fl));
            end
        end
        repeat (4) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL rand_drain: got %0d outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        reset         = 1'b1;
        in_valid      = 1'b0;
        pc_F          = 32'h0;
        instruction_F = 32'h0;
        flush         = 1'b0;
        id_out_ready  = 1'b0;
        #2;
        test_reset();
        test_single();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
